// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the M stage: bus widths, memory access sizes,
// the control word carried through EX/MEM, and the alignment rule.
package memory_stage_pkg;

    typedef logic [31:0] reg_bus_t;
    typedef logic [31:0] mem_data_bus_t;
    typedef logic [3:0]  dmem_be_bus_t;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef struct packed {
        logic       mem_re;
        logic       mem_we;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       reg_we;
        logic [4:0] rd;
    } controlsgs_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == MEM_SIZE_H) && addr_lo[0]) ||
               ((size == MEM_SIZE_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory port with req/gnt address phase and rvalid response phase.
interface memory_stage_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/memory_stage_load_align.sv
// Load lane select and sign/zero extension of a 32-bit memory word.
module load_align
    import memory_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MEM_SIZE_B: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            MEM_SIZE_H: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default:    data = rdata;
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// Pipeline M stage: load/store sequencing on the data-memory port, stall
// generation while a transaction is outstanding, and the MEM/WB register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m_valid,
    input  mem_data_bus_t        m_alu_y,
    input  reg_bus_t             m_wdata,
    input  controlsgs_t          m_ctrl,
    output reg_bus_t             m_regwd,
    output logic                 stall_m,
    output logic                 m_misalign,
    memory_stage_if.master       dmem,
    output reg_bus_t             w_regwd,
    output logic [4:0]           w_rd,
    output logic                 w_reg_we
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e       state_q, state_d;
    logic         mem_op, misaligned, go, req_c;
    dmem_be_bus_t be_c;
    logic [31:0]  wdata_c;
    reg_bus_t     load_data;

    assign mem_op     = m_valid & (m_ctrl.mem_re | m_ctrl.mem_we);
    assign misaligned = mem_op & is_misaligned(m_ctrl.mem_size, m_alu_y[1:0]);
    assign go         = mem_op & ~misaligned;
    assign m_misalign = misaligned;
    assign m_regwd    = m_alu_y;

    // Store lanes: replicate the datum so the byte enables alone pick the lane.
    always_comb begin
        case (m_ctrl.mem_size)
            MEM_SIZE_B: begin
                be_c    = 4'b0001 << m_alu_y[1:0];
                wdata_c = {4{m_wdata[7:0]}};
            end
            MEM_SIZE_H: begin
                be_c    = 4'b0011 << {m_alu_y[1], 1'b0};
                wdata_c = {2{m_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'hF;
                wdata_c = m_wdata;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        stall_m = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    req_c = 1'b1;
                    if (!dmem.gnt) begin
                        state_d = REQ;
                        stall_m = 1'b1;
                    end else if (!m_ctrl.mem_we) begin
                        state_d = RESP;
                        stall_m = 1'b1;
                    end
                end
            end
            REQ: begin
                req_c = 1'b1;
                if (dmem.gnt && m_ctrl.mem_we) begin
                    state_d = IDLE;
                end else begin
                    stall_m = 1'b1;
                    if (dmem.gnt) state_d = RESP;
                end
            end
            RESP: begin
                if (dmem.rvalid) state_d = IDLE;
                else             stall_m = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dmem.req   = req_c;
    assign dmem.we    = req_c & m_ctrl.mem_we;
    assign dmem.addr  = req_c ? {m_alu_y[ADDR_W-1:2], 2'b00} : '0;
    assign dmem.be    = req_c ? be_c : '0;
    assign dmem.wdata = req_c ? wdata_c : '0;

    load_align u_load_align (
        .rdata       (dmem.rdata),
        .addr_lo     (m_alu_y[1:0]),
        .size        (m_ctrl.mem_size),
        .is_unsigned (m_ctrl.mem_unsigned),
        .data        (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // MEM/WB boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_regwd  <= '0;
            w_rd     <= '0;
            w_reg_we <= 1'b0;
        end else if (!stall_m) begin
            w_regwd  <= m_ctrl.mem_re ? load_data : m_alu_y;
            w_rd     <= m_ctrl.rd;
            w_reg_we <= m_valid & m_ctrl.reg_we & ~misaligned;
        end
    end
endmodule
